// File: rtl/mdu_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one result bit per CALC cycle.
// Optional macro MDU_EARLY_TERM_EN: multiply leaves CALC once the remaining multiplier is zero.
module mdu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             oper,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic               op_div, neg_res, neg_a, dz;

  logic               a_neg, b_neg, b_zero, last_iter, ge;
  logic [WIDTH-1:0]   mag_a, mag_b, rem_nx;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] div_nx, prod;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  always_comb begin
    a_neg  = sign & a[WIDTH-1];
    b_neg  = sign & b[WIDTH-1];
    mag_a  = a_neg ? -a : a;
    mag_b  = b_neg ? -b : b;
    b_zero = (b == '0);
  end

  // Restoring divide step: acc holds {remainder, dividend/quotient shifting left}.
  always_comb begin
    trial  = acc[2*WIDTH-1:WIDTH-1];
    ge     = (trial >= {1'b0, mcand[WIDTH-1:0]});
    rem_nx = trial[WIDTH-1:0] - mcand[WIDTH-1:0];
    if (ge) div_nx = {rem_nx, acc[WIDTH-2:0], 1'b1};
    else    div_nx = {acc[2*WIDTH-2:0], 1'b0};
  end

  always_comb begin
    last_iter = (cnt == CNT_W'(WIDTH-1));
`ifdef MDU_EARLY_TERM_EN
    if (!op_div && (mplier[WIDTH-1:1] == '0)) last_iter = 1'b1;
`endif
  end

  // Sign correction; the divide-by-zero path left |a| in acc, so re-negating restores raw a.
  always_comb begin
    prod = neg_res ? -acc : acc;
    if (dz) begin
      fix_hi = neg_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      fix_lo = '1;
    end else if (op_div) begin
      fix_hi = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      fix_lo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end else begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (oper && b_zero) ? FIX : CALC;
      CALC: begin
        if (cancel)         state_nx = IDLE;
        else if (last_iter) state_nx = FIX;
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      op_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_a   <= 1'b0;
      dz      <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      div0    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_div  <= oper;
            neg_a   <= a_neg;
            neg_res <= a_neg ^ b_neg;
            dz      <= oper & b_zero;
            cnt     <= '0;
            mplier  <= mag_b;
            if (oper) begin
              acc   <= {{WIDTH{1'b0}}, mag_a};
              mcand <= {{WIDTH{1'b0}}, mag_b};
            end else begin
              acc   <= '0;
              mcand <= {{WIDTH{1'b0}}, mag_a};
            end
          end else begin
            if (we_hi) hi <= wdata;
            if (we_lo) lo <= wdata;
          end
        end
        CALC: begin
          if (!cancel) begin
            cnt <= cnt + CNT_W'(1);
            if (op_div) begin
              acc <= div_nx;
            end else begin
              if (mplier[0]) acc <= acc + mcand;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
            end
          end
        end
        FIX: begin
          if (!cancel) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            div0 <= dz;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: vector table of multiply/divide results plus
// cancel, reset and HI/LO write-precedence sequences.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, oper, sign, cancel, we_hi, we_lo;
  logic [31:0] a, b, wdata;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_hi, m_lo;
  logic        m_div0;

  typedef struct {
    logic        oper;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
  } vec_t;

  vec_t vecs[15];

  mdu_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .oper(oper), .sign(sign),
    .a(a), .b(b), .cancel(cancel), .we_hi(we_hi), .we_lo(we_lo),
    .wdata(wdata), .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Edges counted from 1 = the edge that samples start.
  function automatic int exp_lat(input logic op, input logic sg, input logic [31:0] bb);
    logic [31:0] mb;
    int n;
    if (op) return (bb == 32'h0) ? 2 : 34;
    mb = (sg && bb[31]) ? -bb : bb;
    n = 1;
    for (int i = 0; i < 32; i++) if (mb[i]) n = i + 1;
`ifdef MDU_EARLY_TERM_EN
    return n + 2;
`else
    return (n > 0) ? 34 : 34;
`endif
  endfunction

  task automatic run_op(input string nm, input logic op, input logic sg,
                        input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed,
                        input logic can, input logic whs, input logic wrb);
    int lat;
    logic hold_ok;
    lat = exp_lat(op, sg, ib);
    hold_ok = 1'b1;
    start = 1'b1; oper = op; sign = sg; a = ia; b = ib;
    cancel = can; we_hi = whs; we_lo = 1'b0; wdata = 32'hDEADBEEF;
    for (int e = 1; e <= lat; e++) begin
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b0;
      we_hi = wrb; we_lo = wrb; wdata = 32'h5A5A5A5A;
      if (e < lat) begin
        if (busy !== 1'b1 || done !== 1'b0 || hi !== m_hi || lo !== m_lo || div0 !== m_div0)
          hold_ok = 1'b0;
      end
    end
    we_hi = 1'b0; we_lo = 1'b0;
    chk({nm, "_hold"}, {31'b0, hold_ok}, 32'd1);
    chk({nm, "_done"}, {31'b0, done}, 32'd1);
    chk({nm, "_busy"}, {31'b0, busy}, 32'd0);
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
    chk({nm, "_div0"}, {31'b0, div0}, {31'b0, ed});
    m_hi = eh; m_lo = el; m_div0 = ed;
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'd7,        32'd9,        32'h00000007, 32'h00000000, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 32'h00001234, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0};

    rst = 1'b1; start = 1'b0; oper = 1'b0; sign = 1'b0; a = '0; b = '0;
    cancel = 1'b0; we_hi = 1'b0; we_lo = 1'b0; wdata = '0;
    m_hi = '0; m_lo = '0; m_div0 = 1'b0;
    #12 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_div0", {31'b0, div0}, 32'd0);

    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), vecs[i].oper, vecs[i].sign, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].div0, 1'b0, 1'b0, i[0]);

    // Cancel a multiply in cycle 10: back to IDLE, nothing written.
    start = 1'b1; oper = 1'b0; sign = 1'b0; a = 32'd3; b = 32'hFFFFFFFF;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel_busy", {31'b0, busy}, 32'd0);
    chk("cancel_done", {31'b0, done}, 32'd0);
    chk("cancel_hi", hi, m_hi);
    chk("cancel_lo", lo, m_lo);
    chk("cancel_div0", {31'b0, div0}, {31'b0, m_div0});
    run_op("restart", 1'b0, 1'b0, 32'd3, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFD, 1'b0,
           1'b0, 1'b0, 1'b0);

    // Cancel asserted in IDLE together with start does not block the start.
    run_op("idle_cancel", 1'b1, 1'b0, 32'd50, 32'd8, 32'h00000002, 32'h00000006, 1'b0,
           1'b1, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a divide.
    start = 1'b1; oper = 1'b1; sign = 1'b0; a = 32'hFFFFFFFF; b = 32'd3;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_div0", {31'b0, div0}, 32'd0);
    m_hi = '0; m_lo = '0; m_div0 = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("postrst_busy", {31'b0, busy}, 32'd0);
    chk("postrst_done", {31'b0, done}, 32'd0);

    // MTLO in IDLE.
    we_lo = 1'b1; wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    we_lo = 1'b0;
    chk("mtlo_lo", lo, 32'hA5A5A5A5);
    chk("mtlo_hi", hi, 32'h0);
    m_lo = 32'hA5A5A5A5;

    // start and MTHI in the same cycle: the write is dropped.
    run_op("start_mthi", 1'b0, 1'b0, 32'd2, 32'd3, 32'h00000000, 32'h00000006, 1'b0,
           1'b0, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
